// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampled UART receiver with 3-sample majority voting and a receive FIFO.
module uart_rx_oversampled #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 err_clr,
  output logic                 busy
);
  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_A = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_B = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_C = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0] N_DATA = 4'(DATA_BITS);
  localparam logic [3:0] N_STOP = 4'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;
  state_t state_q, state_d;
  logic rx_s1_q, rx_s2_q;
  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] smp_q, smp_d;
  logic [1:0] ones_q, ones_d;
  logic [3:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic perr_q, perr_d, ferr_q, ferr_d, push_q, push_d;
  logic [DATA_BITS+1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic overrun_q;
  logic rx_s, tick, vote, bit_end, maj, start_det, full, pop, wr_en;
  assign rx_s = rx_s2_q;
  assign tick = div_q == DIV_LAST;
  assign vote = tick && smp_q == S_C;
  assign bit_end = tick && smp_q == S_LAST;
  assign maj = (ones_q + {1'b0, rx_s}) >= 2'd2;
  assign div_d = (start_det || tick) ? '0 : div_q + DW'(1);
  assign busy = state_q != IDLE;
  // The sample counter free-runs; a start edge realigns it together with the divider.
  always_comb begin
    state_d = state_q;
    smp_d = tick ? (smp_q == S_LAST ? '0 : smp_q + SW'(1)) : smp_q;
    ones_d = (tick && (smp_q == S_A || smp_q == S_B)) ? ones_q + {1'b0, rx_s} : (vote ? 2'd0 : ones_q);
    bit_d = bit_q;
    shift_d = shift_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    push_d = 1'b0;
    start_det = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        start_det = 1'b1;
        smp_d = '0;
        ones_d = '0;
        bit_d = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
      end
      START: state_d = (vote && maj) ? IDLE : (bit_end ? DATA : START);
      DATA: begin
        if (vote) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          bit_d = bit_q + 4'd1;
        end
        if (bit_end && bit_q == N_DATA) begin
          state_d = PARITY != 0 ? PAR : STOP;
          bit_d = '0;
        end
      end
      PAR: begin
        if (vote) perr_d = ((^shift_q) ^ maj) == (PARITY == 2);
        if (bit_end) state_d = STOP;
      end
      STOP: if (vote) begin
        ferr_d = ferr_q | ~maj;
        bit_d = bit_q + 4'd1;
        if (bit_q == N_STOP) begin
          push_d = 1'b1;
          state_d = (ferr_q | ~maj) ? WAIT_HIGH : IDLE;
        end
      end
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      state_q <= IDLE;
      div_q <= '0;
      smp_q <= '0;
      ones_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      push_q <= 1'b0;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      state_q <= state_d;
      div_q <= div_d;
      smp_q <= smp_d;
      ones_q <= ones_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      push_q <= push_d;
    end
  end
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign data_valid = cnt_q != '0;
  assign pop = data_valid && data_ready;
  assign wr_en = push_q && (!full || pop);
  assign overrun = overrun_q;
  assign {data, parity_err, frame_err} = data_valid ? mem_q[rd_q] : '0;
  // The frame registers stay stable for the cycle after the final stop vote, so they feed the FIFO directly.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= {shift_q, perr_q, ferr_q};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_q <= wr_q + AW'(wr_en);
      rd_q <= rd_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
      overrun_q <= (push_q && full && !pop) || (overrun_q && !err_clr);
    end
  end
endmodule

// File: doc/uart_rx_oversampled.md
UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100_000_000, meaning clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, meaning line bit rate.
REQ-003 The block SHALL have parameter OVERSAMPLE, default 16, meaning samples per bit; legal values are even and at least 8.
REQ-004 The block SHALL have parameter DATA_BITS, default 8, meaning payload width; legal range is 5 to 9.
REQ-005 The block SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-006 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits checked; legal values are 1 and 2.
REQ-007 The block SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries; must be a power of 2 and at least 2.
REQ-008 The block SHALL have these ports, in this order:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  asynchronous serial line, idle high.
- data  output  DATA_BITS  FIFO head payload.
- data_valid  output  1  FIFO non-empty; head is presented.
- data_ready  input  1  consumer accepts head.
- parity_err  output  1  parity error flag of the head entry.
- frame_err  output  1  stop-bit error flag of the head entry.
- overrun  output  1  sticky; a frame was dropped because the FIFO was full.
- err_clr  input  1  clears overrun.
- busy  output  1  receiver is not in IDLE.

Function
REQ-009 The block SHALL pass rx through a 2-flop synchronizer whose flops reset to 1; all logic SHALL use only the synchronized value.
REQ-010 The block SHALL generate a sample tick once every CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks (integer division, minimum 1), using a divider counter sized by $clog2.
REQ-011 The tick divider SHALL restart from 0 on the cycle a start edge is detected, so that the sample phase is aligned to the edge.
REQ-012 The receiver state machine SHALL have the states IDLE, START, DATA, PAR, STOP and WAIT_HIGH.
REQ-013 In IDLE, a synchronized rx of 0 SHALL move the receiver to START and clear the per-bit sample counter.
REQ-014 Each bit value SHALL be the majority of 3 samples taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
REQ-015 In START, a majority of 1 SHALL be treated as a false start: return to IDLE, push nothing, raise no flags.
REQ-016 Data bits SHALL be received LSB first into a DATA_BITS shift register; after DATA_BITS bits the receiver SHALL go to PAR if PARITY is nonzero, otherwise to STOP.
REQ-017 In PAR, parity_err for the frame SHALL be set when the XOR of the data bits and the parity bit equals 0 for odd parity or 1 for even parity.
REQ-018 In STOP, each of the STOP_BITS bits SHALL be sampled; any sampled 0 SHALL set frame_err for the frame.
REQ-019 The decision after the final stop-bit majority sample SHALL be:
- The frame {data, parity_err, frame_err} is pushed into the FIFO on the next clock.
- The receiver goes to IDLE if the stop bit was good, or to WAIT_HIGH if frame_err is set.
- The receiver does not wait for the end of the stop bit.
REQ-020 WAIT_HIGH SHALL stay until synchronized rx is 1 and then go to IDLE, so that a break does not retrigger reception.
REQ-021 busy SHALL be 0 only in IDLE.
REQ-022 The FIFO SHALL present its head combinationally on data, parity_err and frame_err; data_valid SHALL be equal to not empty.
REQ-023 A pop SHALL occur when data_valid and data_ready are both 1.
REQ-024 A push into an empty FIFO SHALL make data_valid assert on the following clock; there is no bypass path.
REQ-025 A push while the FIFO is full with no pop SHALL drop the new frame, leave the FIFO contents unchanged and set overrun.
REQ-026 A push and a pop in the same cycle while the FIFO is full SHALL both succeed and SHALL NOT set overrun.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with a count or an extra pointer bit.
REQ-028 overrun SHALL remain set until err_clr is 1; if err_clr and a new overrun occur in the same cycle, overrun SHALL end up set.

Reset
REQ-029 Asserting rst_n low SHALL asynchronously force:
- receiver state to IDLE, synchronizer flops to 1, all counters to 0;
- FIFO to empty;
- data to 0, data_valid, parity_err, frame_err, overrun and busy to 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame.
REQ-031 After reset releases, a new frame SHALL be accepted only when a falling edge is seen in IDLE.

Verification
Test parameters for all scenarios: CLK_FREQ=1_843_200, BAUD_RATE=115200, OVERSAMPLE=16, so 1 tick per clock and 16 clocks per bit.
REQ-032 8N1 frame 0xA5 with data_ready=1 -> data=0xA5, data_valid high for exactly 1 cycle, starting 2 clocks after the mid-stop sample, no error flags set.
REQ-033 PARITY=2, 8E1, frame 0x03 sent with parity bit 1 -> data=0x03 with parity_err=1 and frame_err=0.
REQ-034 Stop bit held at 0 for 40 bit times -> one entry pushed with frame_err=1, the receiver stays in WAIT_HIGH until rx rises, and no further entries are pushed.
REQ-035 A 4-clock low glitch on the idle line -> false start, busy returns to 0, FIFO stays empty.
REQ-036 With data_ready=0, send 5 frames 0x01 to 0x05 into FIFO_DEPTH=4 -> overrun=1 and popping yields 0x01, 0x02, 0x03, 0x04; then err_clr=1 -> overrun=0.
REQ-037 rst_n pulsed low in the middle of the DATA state of a frame, then the frame 0x5A sent -> only 0x5A is received.
